// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment scanner:
// active-high segment patterns, FSM state encoding and digit count.
package seg7_scan_display_pkg;

   localparam int NUM_DIGITS = 4;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SCAN  = 1'b1
   } state_t;

   // Segment patterns {g,f,e,d,c,b,a}, active-high (inverted at the pins)
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Combinational hex nibble to 7-segment decoder, active-high segments.
module seg7_scan_display_hex_to_seg7
   import seg7_scan_display_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   // Table lookup of the glyph for one hex digit
   always_comb begin
      seg = SEG_0;
      case (nib)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_display.sv
// 4-digit common-anode scanner for the CPU debug values. Values are
// snapshotted on the falling edge of clk_cpu (half a CPU period after they
// change) and scanned digit by digit with optional blanking between digits.
module seg7_scan_display
   import seg7_scan_display_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clk_cpu,
   input  logic        freeze,
   input  logic [15:0] dat_in,
   input  logic [3:0]  dp_in,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic [3:0]  dig_n
);

   localparam int CNT_MAX    = (SCAN_DIV > BLANK_CYCLES) ?
                               ((SCAN_DIV > 2) ? SCAN_DIV : 2) :
                               ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
   localparam int CNT_W      = $clog2(CNT_MAX);
   localparam int IDX_W      = $clog2(NUM_DIGITS);
   localparam int SCAN_LAST  = SCAN_DIV - 1;
   localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

   logic             clk_cpu_d;
   logic             fall;
   logic [15:0]      snap;
   logic [3:0]       dps;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [3:0]       nib;
   logic [6:0]       seg;

   assign fall = clk_cpu_d & ~clk_cpu;

   // Falling-edge detect on clk_cpu and snapshot capture (freeze wins)
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         clk_cpu_d <= 1'b0;
         snap      <= '0;
         dps       <= '0;
      end else begin
         clk_cpu_d <= clk_cpu;
         if (fall && !freeze) begin
            snap <= dat_in;
            dps  <= dp_in;
         end
      end
   end

   // Next state: blank gap, then drive the next digit; with no gap, scan back to back
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      idx_nxt   = idx;
      case (state)
         ST_BLANK: begin
            if (BLANK_CYCLES == 0 || cnt == CNT_W'(BLANK_LAST)) begin
               cnt_nxt   = '0;
               idx_nxt   = idx + 1'b1;
               state_nxt = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (cnt == CNT_W'(SCAN_LAST)) begin
               cnt_nxt = '0;
               if (BLANK_CYCLES == 0) begin
                  idx_nxt = idx + 1'b1;
               end else begin
                  state_nxt = ST_BLANK;
               end
            end
         end
         default: begin
            state_nxt = ST_BLANK;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign nib = snap[4*idx_nxt +: 4];

   seg7_scan_display_hex_to_seg7 u_hex (
      .nib (nib),
      .seg (seg)
   );

   // State/counter registers and registered pin drive, updated on the same edge
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_BLANK;
         cnt   <= '0;
         idx   <= IDX_W'(NUM_DIGITS - 1);
         seg_n <= 7'h7F;
         dp_n  <= 1'b1;
         dig_n <= 4'hF;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         if (state_nxt == ST_SCAN) begin
            seg_n <= ~seg;
            dp_n  <= ~dps[idx_nxt];
            dig_n <= ~(4'b0001 << idx_nxt);
         end else begin
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
            dig_n <= 4'hF;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with SCAN_DIV=4: one instance with
// BLANK_CYCLES=2 and one without blanking, sharing the same stimulus.
module tb_seg7_scan_display;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clk_cpu;
   logic        freeze;
   logic [15:0] dat_in;
   logic [3:0]  dp_in;
   logic [6:0]  seg_n,  seg_n0;
   logic        dp_n,   dp_n0;
   logic [3:0]  dig_n,  dig_n0;

   int n_run  = 0;
   int n_fail = 0;

   logic [3:0] frame [24];

   seg7_scan_display #(.SCAN_DIV(4), .BLANK_CYCLES(2)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .clk_cpu (clk_cpu),
      .freeze  (freeze),
      .dat_in  (dat_in),
      .dp_in   (dp_in),
      .seg_n   (seg_n),
      .dp_n    (dp_n),
      .dig_n   (dig_n)
   );

   seg7_scan_display #(.SCAN_DIV(4), .BLANK_CYCLES(0)) u_dut0 (
      .clk     (clk),
      .reset_n (reset_n),
      .clk_cpu (clk_cpu),
      .freeze  (freeze),
      .dat_in  (dat_in),
      .dp_in   (dp_in),
      .seg_n   (seg_n0),
      .dp_n    (dp_n0),
      .dig_n   (dig_n0)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_fall();
      clk_cpu = 1'b1;
      tick();
      clk_cpu = 1'b0;
      tick();
   endtask

   // Go to the start of a blank gap, then to the first cycle of digit d
   task automatic wait_digit(input int d, input string tag);
      logic [3:0] exp_dig;
      int n;
      exp_dig = ~(4'b0001 << d);
      n = 0;
      while (dig_n !== 4'hF && n < 100) begin
         tick();
         n++;
      end
      while (dig_n !== exp_dig && n < 100) begin
         tick();
         n++;
      end
      check(tag, {28'd0, dig_n}, {28'd0, exp_dig});
   endtask

   initial begin
      logic [3:0] exp_a, exp_b;
      frame = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF,
                4'hD, 4'hD, 4'hD, 4'hD, 4'hF, 4'hF,
                4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF,
                4'h7, 4'h7, 4'h7, 4'h7, 4'hF, 4'hF};
      reset_n = 1'b0;
      clk_cpu = 1'b0;
      freeze  = 1'b0;
      dat_in  = 16'h0000;
      dp_in   = 4'h0;

      // Reset held for three clocks
      repeat (3) tick();
      check("rst_seg",  {25'd0, seg_n}, 32'h7F);
      check("rst_dig",  {28'd0, dig_n}, 32'hF);
      check("rst_dp",   {31'd0, dp_n},  32'h1);
      check("rst_dig0", {28'd0, dig_n0}, 32'hF);

      // First two frames after release, both instances
      reset_n = 1'b1;
      for (int k = 1; k <= 48; k++) begin
         tick();
         exp_a = (k == 1) ? 4'hF : frame[(k - 2) % 24];
         exp_b = ~(4'b0001 << (((k - 1) / 4) % 4));
         check($sformatf("frame_dig_k%0d", k), {28'd0, dig_n}, {28'd0, exp_a});
         check($sformatf("frame_seg_k%0d", k), {25'd0, seg_n},
               (exp_a == 4'hF) ? 32'h7F : 32'h40);
         check($sformatf("noblank_dig_k%0d", k), {28'd0, dig_n0}, {28'd0, exp_b});
      end

      // Snapshot only on a falling clk_cpu edge
      dat_in  = 16'h9A5C;
      clk_cpu = 1'b1;
      tick();
      tick();
      check("rise_no_snap", {16'd0, u_dut.snap}, 32'h0000);
      clk_cpu = 1'b0;
      tick();
      check("fall_snap", {16'd0, u_dut.snap}, 32'h9A5C);
      wait_digit(0, "snap_wait_d0");
      check("snap_d0_C", {25'd0, seg_n}, 32'h46);
      check("snap_d0_dp", {31'd0, dp_n}, 32'h1);
      wait_digit(1, "snap_wait_d1");
      check("snap_d1_5", {25'd0, seg_n}, 32'h12);
      wait_digit(2, "snap_wait_d2");
      check("snap_d2_A", {25'd0, seg_n}, 32'h08);
      wait_digit(3, "snap_wait_d3");
      check("snap_d3_9", {25'd0, seg_n}, 32'h10);

      // Freeze holds the snapshot while scanning continues
      dat_in = 16'h1234;
      cpu_fall();
      check("load_1234", {16'd0, u_dut.snap}, 32'h1234);
      freeze = 1'b1;
      dat_in = 16'hFFFF;
      cpu_fall();
      check("freeze_hold", {16'd0, u_dut.snap}, 32'h1234);
      freeze  = 1'b0;
      clk_cpu = 1'b1;
      tick();
      freeze  = 1'b1;
      clk_cpu = 1'b0;
      tick();
      check("freeze_coincident", {16'd0, u_dut.snap}, 32'h1234);
      freeze = 1'b0;
      tick();
      check("freeze_release_no_fall", {16'd0, u_dut.snap}, 32'h1234);
      freeze = 1'b1;
      wait_digit(0, "frz_wait_d0");
      check("frz_d0_4", {25'd0, seg_n}, 32'h19);
      wait_digit(1, "frz_wait_d1");
      check("frz_d1_3", {25'd0, seg_n}, 32'h30);
      wait_digit(2, "frz_wait_d2");
      check("frz_d2_2", {25'd0, seg_n}, 32'h24);
      wait_digit(3, "frz_wait_d3");
      check("frz_d3_1", {25'd0, seg_n}, 32'h79);
      freeze = 1'b0;

      // Decimal point follows digit 3 only
      dat_in = 16'h1234;
      dp_in  = 4'b1000;
      cpu_fall();
      wait_digit(3, "dp_wait_d3");
      check("dp_d3_on", {31'd0, dp_n}, 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("dp_d3_dig_%0d", k), {28'd0, dig_n}, 32'h7);
         check($sformatf("dp_d3_on_%0d", k), {31'd0, dp_n}, 32'h0);
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         check($sformatf("dp_blank_dig_%0d", k), {28'd0, dig_n}, 32'hF);
         check($sformatf("dp_blank_off_%0d", k), {31'd0, dp_n}, 32'h1);
      end
      tick();
      check("dp_d0_dig", {28'd0, dig_n}, 32'hE);
      check("dp_d0_off", {31'd0, dp_n}, 32'h1);

      // Reset for one clock in the middle of digit 2
      wait_digit(2, "mid_wait_d2");
      tick();
      reset_n = 1'b0;
      tick();
      check("mid_rst_dig",  {28'd0, dig_n}, 32'hF);
      check("mid_rst_seg",  {25'd0, seg_n}, 32'h7F);
      check("mid_rst_dp",   {31'd0, dp_n},  32'h1);
      check("mid_rst_snap", {16'd0, u_dut.snap}, 32'h0000);
      reset_n = 1'b1;
      tick();
      check("mid_rel_blank", {28'd0, dig_n}, 32'hF);
      check("mid_rel_d0_nb", {28'd0, dig_n0}, 32'hE);
      tick();
      check("mid_rel_d0", {28'd0, dig_n}, 32'hE);
      check("mid_rel_seg0", {25'd0, seg_n}, 32'h40);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
